// File: rtl/iir_biquad_seq_pkg.sv
// Shared definitions for the biquad filter family: coefficient ROM map,
// sequencer states and the MAC-step to ROM-address mapping.
package iir_biquad_seq_pkg;

   localparam logic [3:0] SEL_A0 = 4'd0;
   localparam logic [3:0] SEL_A1 = 4'd1;
   localparam logic [3:0] SEL_A2 = 4'd2;
   localparam logic [3:0] SEL_B0 = 4'd5;
   localparam logic [3:0] SEL_B1 = 4'd6;
   localparam logic [3:0] SEL_B2 = 4'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // MAC step order: feed-forward taps first, then the feedback taps
   function automatic logic [3:0] sel_for_step(input logic [2:0] k);
      logic [3:0] sel;
      case (k)
         3'd0:    sel = SEL_B0;
         3'd1:    sel = SEL_B1;
         3'd2:    sel = SEL_B2;
         3'd3:    sel = SEL_A1;
         3'd4:    sel = SEL_A2;
         default: sel = SEL_A0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/iir_biquad_seq_mac_sat.sv
// Signed multiply-accumulate with clear, followed by an arithmetic
// right shift (floor) and saturation back to the sample width.
module iir_biquad_seq_mac_sat
   import iir_biquad_seq_pkg::*;
#(
   parameter int cant_bits = 25,
   parameter int frac_bits = 14
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        en,
   input  logic signed [cant_bits-1:0] coef,
   input  logic signed [cant_bits-1:0] opnd,
   output logic signed [cant_bits-1:0] y_sat
);

   localparam int acc_w = 2*cant_bits + 3;
   localparam logic signed [acc_w-1:0] sat_max_c =
      {{(acc_w-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
   localparam logic signed [acc_w-1:0] sat_min_c =
      {{(acc_w-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};

   logic signed [2*cant_bits-1:0] prod_s;
   logic signed [acc_w-1:0]       acc_r;
   logic signed [acc_w-1:0]       shifted_s;

   assign prod_s    = (2*cant_bits)'(coef) * (2*cant_bits)'(opnd);
   assign shifted_s = acc_r >>> frac_bits;

   // accumulator: three guard bits absorb the five-term sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= '0;
      end else if (clr) begin
         acc_r <= '0;
      end else if (en) begin
         acc_r <= acc_r + {{3{prod_s[2*cant_bits-1]}}, prod_s};
      end else begin
         acc_r <= acc_r;
      end
   end

   // clamp the scaled sum into the signed sample range
   always_comb begin
      y_sat = shifted_s[cant_bits-1:0];
      if (shifted_s > sat_max_c) begin
         y_sat = sat_max_c[cant_bits-1:0];
      end else if (shifted_s < sat_min_c) begin
         y_sat = sat_min_c[cant_bits-1:0];
      end else begin
         y_sat = shifted_s[cant_bits-1:0];
      end
   end

endmodule

// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad: walks the coefficient ROM over five MAC steps with
// one shared multiplier and emits one saturated output per input sample.
module iir_biquad_seq
   import iir_biquad_seq_pkg::*;
#(
   parameter int cant_bits = 25,
   parameter int frac_bits = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 clear,
   input  logic [cant_bits-1:0] x_in,
   input  logic [cant_bits-1:0] cte,
   output logic [3:0]           sel_cte,
   output logic [cant_bits-1:0] y_out,
   output logic                 done,
   output logic                 busy
);

   state_t state_r, state_s;
   logic [2:0] k_r;
   logic signed [cant_bits-1:0] x0_r, x1_r, x2_r, y1_r, y2_r;
   logic signed [cant_bits-1:0] opnd_s, y_sat_s;
   logic load_s, acc_en_s, hist_clr_s, fin_s;

   assign sel_cte = (state_r == MAC) ? sel_for_step(k_r) : SEL_A0;

   // next-state and datapath control
   always_comb begin
      state_s    = state_r;
      load_s     = 1'b0;
      acc_en_s   = 1'b0;
      hist_clr_s = 1'b0;
      fin_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = MAC;
               load_s  = 1'b1;
            end else if (clear) begin
               hist_clr_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         MAC: begin
            acc_en_s = 1'b1;
            if (k_r == 3'd4) begin
               state_s = FIN;
            end else begin
               state_s = MAC;
            end
         end
         FIN: begin
            fin_s   = 1'b1;
            state_s = IDLE;
         end
         default: state_s = IDLE;
      endcase
   end

   // operand tracks the ROM address issued for step k
   always_comb begin
      case (k_r)
         3'd0:    opnd_s = x0_r;
         3'd1:    opnd_s = x1_r;
         3'd2:    opnd_s = x2_r;
         3'd3:    opnd_s = y1_r;
         3'd4:    opnd_s = y2_r;
         default: opnd_s = '0;
      endcase
   end

   // FSM state, step counter, sample history and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         k_r     <= 3'd0;
         x0_r    <= '0;
         x1_r    <= '0;
         x2_r    <= '0;
         y1_r    <= '0;
         y2_r    <= '0;
         y_out   <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_r <= state_s;
         done    <= fin_s;
         busy    <= (state_s != IDLE);
         if (load_s) begin
            x0_r <= signed'(x_in);
            k_r  <= 3'd0;
         end else if (acc_en_s) begin
            k_r <= k_r + 3'd1;
         end else begin
            k_r <= k_r;
         end
         if (hist_clr_s) begin
            x1_r <= '0;
            x2_r <= '0;
            y1_r <= '0;
            y2_r <= '0;
         end else if (fin_s) begin
            x2_r  <= x1_r;
            x1_r  <= x0_r;
            y2_r  <= y1_r;
            y1_r  <= y_sat_s;
            y_out <= y_sat_s;
         end else begin
            y_out <= y_out;
         end
      end
   end

   iir_biquad_seq_mac_sat #(
      .cant_bits(cant_bits),
      .frac_bits(frac_bits)
   ) u_mac_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load_s),
      .en    (acc_en_s),
      .coef  (signed'(cte)),
      .opnd  (opnd_s),
      .y_sat (y_sat_s)
   );

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed-vector bench for iir_biquad_seq with a behavioural coefficient ROM
// (200 Hz low-pass set or a saturation stub).
module tb_iir_biquad_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        clear;
   logic [24:0] x_in;
   logic [24:0] cte;
   logic [3:0]  sel_cte;
   logic [24:0] y_out;
   logic        done;
   logic        busy;
   int          rom_mode;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   iir_biquad_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .clear   (clear),
      .x_in    (x_in),
      .cte     (cte),
      .sel_cte (sel_cte),
      .y_out   (y_out),
      .done    (done),
      .busy    (busy)
   );

   // coefficient ROM model
   always_comb begin
      cte = 25'd0;
      if (rom_mode == 0) begin
         case (sel_cte)
            4'd0:    cte = 25'h0004000;
            4'd1:    cte = 25'h0007D71;
            4'd2:    cte = 25'h1FFC287;
            4'd5:    cte = 25'd3;
            4'd6:    cte = 25'd7;
            4'd7:    cte = 25'd3;
            default: cte = 25'd0;
         endcase
      end else begin
         case (sel_cte)
            4'd5:    cte = 25'h0FFFFFF;
            default: cte = 25'd0;
         endcase
      end
   end

   task automatic pulse_start(input logic [24:0] x);
      @(negedge clk);
      start = 1'b1;
      x_in  = x;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // lat = edges after the start-sampling edge until done is seen (-1: none)
   task automatic run_sample(input logic [24:0] x, output logic [24:0] y, output int lat);
      pulse_start(x);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      y = y_out;
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if (sel_cte !== 4'd0 || y_out !== 25'd0 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: sel=%0d y=%h done=%b busy=%b, want 0 0 0 0", sel_cte, y_out, done, busy);
      end
   endtask

   task automatic test_impulse(input string tag);
      logic [24:0] xs [3];
      logic [24:0] ys [3];
      logic [24:0] y;
      int lat;
      xs = '{25'h0004000, 25'd0, 25'd0};
      ys = '{25'd3, 25'd12, 25'd23};
      rom_mode = 0;
      for (int i = 0; i < 3; i++) begin
         run_sample(xs[i], y, lat);
         checks++;
         if (y !== ys[i]) begin
            errors++;
            $display("FAIL %s_y%0d: got %h want %h", tag, i, y, ys[i]);
         end
         checks++;
         if (lat != 6) begin
            errors++;
            $display("FAIL %s_lat%0d: got %0d want 6", tag, i, lat);
         end
      end
   endtask

   task automatic test_clear();
      logic [24:0] y;
      int lat;
      pulse_clear();
      run_sample(25'd0, y, lat);
      checks++;
      if (y !== 25'd0 || lat != 6) begin
         errors++;
         $display("FAIL clear: got y=%h lat=%0d want 0 6", y, lat);
      end
   endtask

   task automatic test_timing();
      logic [3:0] exp_sel [5];
      exp_sel = '{4'd5, 4'd6, 4'd7, 4'd1, 4'd2};
      rom_mode = 0;
      checks++;
      if (sel_cte !== 4'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_sel: sel=%0d busy=%b want 0 0", sel_cte, busy);
      end
      pulse_start(25'd0);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (sel_cte !== exp_sel[k] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL seq_k%0d: sel=%0d busy=%b done=%b want %0d 1 0", k, sel_cte, busy, done, exp_sel[k]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || sel_cte !== 4'd0) begin
         errors++;
         $display("FAIL fin_cycle: busy=%b done=%b sel=%0d want 1 0 0", busy, done, sel_cte);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL done_cycle: busy=%b done=%b want 0 1", busy, done);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done=%b want 0", done);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      logic [24:0] y;
      int lat;
      rom_mode = 1;
      run_sample(25'h0FFFFFF, y, lat);
      checks++;
      if (y !== 25'h0FFFFFF) begin
         errors++;
         $display("FAIL sat_pos: got %h want 0ffffff", y);
      end
      run_sample(25'h1000000, y, lat);
      checks++;
      if (y !== 25'h1000000) begin
         errors++;
         $display("FAIL sat_neg: got %h want 1000000", y);
      end
      rom_mode = 0;
   endtask

   task automatic test_start_busy();
      int n_done;
      logic [24:0] y;
      rom_mode = 0;
      pulse_clear();
      pulse_start(25'h0004000);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      x_in  = 25'h0008000;
      @(negedge clk);
      start  = 1'b0;
      n_done = 0;
      y      = 25'h1555555;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            n_done++;
            y = y_out;
         end
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL busy_start_count: got %0d dones want 1", n_done);
      end
      checks++;
      if (y !== 25'd3) begin
         errors++;
         $display("FAIL busy_start_y: got %h want 3", y);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n_done;
      rom_mode = 0;
      pulse_start(25'h0004000);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || y_out !== 25'd0 || sel_cte !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b done=%b y=%h sel=%0d want 0 0 0 0", busy, done, y_out, sel_cte);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL mid_reset_done: got %0d dones want 0", n_done);
      end
      @(negedge clk);
      test_impulse("post_reset");
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      clear    = 1'b0;
      x_in     = 25'd0;
      rom_mode = 0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_impulse("impulse");
      test_clear();
      test_timing();
      test_saturation();
      test_start_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
